// File: rtl/axi_sram_slave.sv
// Single-beat AXI3 responder backed by a word-addressed internal memory.
// Define AXI_SLV_DELAY_EN to hold rvalid/bvalid back by RESP_DELAY cycles.
module axi_sram_slave #(
    parameter int ADDR_W     = 12,
    parameter int RESP_DELAY = 3
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_RESP} r_state_e;
    typedef enum logic {W_IDLE, W_RESP} w_state_e;

    logic [31:0] mem_q [2**ADDR_W];

    r_state_e          r_state_q, r_state_d;
    logic [3:0]        rid_q, rid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    w_state_e          w_state_q, w_state_d;
    logic              aw_got_q, aw_got_d;
    logic              w_got_q, w_got_d;
    logic [3:0]        awid_q, awid_d;
    logic [ADDR_W-1:0] aw_idx_q, aw_idx_d;
    logic              awlen_ok_q, awlen_ok_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              wlast_q, wlast_d;
    logic [3:0]        bid_q, bid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              mem_we;

    logic              r_done;
    logic              b_done;

`ifdef AXI_SLV_DELAY_EN
    logic [3:0] rcnt_q, rcnt_d;
    logic [3:0] bcnt_q, bcnt_d;
    assign r_done = (rcnt_q == 4'd0);
    assign b_done = (bcnt_q == 4'd0);
`else
    assign r_done = 1'b1;
    assign b_done = 1'b1;
`endif

    logic unused_ok;
    assign unused_ok = ^{araddr[31:ADDR_W+2], araddr[1:0],
                         awaddr[31:ADDR_W+2], awaddr[1:0],
                         arsize, arburst, awsize, awburst,
                         wid, 4'(RESP_DELAY)};

    assign rlast = 1'b1;
    assign rid   = rid_q;
    assign rdata = rdata_q;
    assign rresp = rresp_q;
    assign bid   = bid_q;
    assign bresp = bresp_q;

    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        arready   = 1'b0;
        rvalid    = 1'b0;
`ifdef AXI_SLV_DELAY_EN
        rcnt_d    = rcnt_q;
`endif
        unique case (r_state_q)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    rid_d = arid;
                    if (arlen != 8'd0) begin
                        rdata_d = 32'd0;
                        rresp_d = SLVERR;
                    end else begin
                        rdata_d = mem_q[araddr[ADDR_W+1:2]];
                        rresp_d = OKAY;
                    end
`ifdef AXI_SLV_DELAY_EN
                    rcnt_d = 4'(RESP_DELAY);
`endif
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                rvalid = r_done;
                if (!r_done) begin
`ifdef AXI_SLV_DELAY_EN
                    rcnt_d = rcnt_q - 4'd1;
`endif
                end else if (rready) begin
                    r_state_d = R_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        w_state_d  = w_state_q;
        aw_got_d   = aw_got_q;
        w_got_d    = w_got_q;
        awid_d     = awid_q;
        aw_idx_d   = aw_idx_q;
        awlen_ok_d = awlen_ok_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wlast_d    = wlast_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        mem_we     = 1'b0;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
`ifdef AXI_SLV_DELAY_EN
        bcnt_d     = bcnt_q;
`endif
        unique case (w_state_q)
            W_IDLE: begin
                awready = !aw_got_q;
                wready  = !w_got_q;
                if (awvalid && !aw_got_q) begin
                    aw_got_d   = 1'b1;
                    awid_d     = awid;
                    aw_idx_d   = awaddr[ADDR_W+1:2];
                    awlen_ok_d = (awlen == 8'd0);
                end
                if (wvalid && !w_got_q) begin
                    w_got_d = 1'b1;
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                    wlast_d = wlast;
                end
                // Commit one cycle after the later of the AW/W captures.
                if (aw_got_q && w_got_q) begin
                    mem_we    = awlen_ok_q && wlast_q;
                    bid_d     = awid_q;
                    bresp_d   = (awlen_ok_q && wlast_q) ? OKAY : SLVERR;
`ifdef AXI_SLV_DELAY_EN
                    bcnt_d    = 4'(RESP_DELAY);
`endif
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = b_done;
                if (!b_done) begin
`ifdef AXI_SLV_DELAY_EN
                    bcnt_d = bcnt_q - 4'd1;
`endif
                end else if (bready) begin
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r_state_q  <= R_IDLE;
            rid_q      <= 4'd0;
            rdata_q    <= 32'd0;
            rresp_q    <= OKAY;
            w_state_q  <= W_IDLE;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            awid_q     <= 4'd0;
            aw_idx_q   <= '0;
            awlen_ok_q <= 1'b0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            wlast_q    <= 1'b0;
            bid_q      <= 4'd0;
            bresp_q    <= OKAY;
`ifdef AXI_SLV_DELAY_EN
            rcnt_q     <= 4'd0;
            bcnt_q     <= 4'd0;
`endif
        end else begin
            r_state_q  <= r_state_d;
            rid_q      <= rid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            w_state_q  <= w_state_d;
            aw_got_q   <= aw_got_d;
            w_got_q    <= w_got_d;
            awid_q     <= awid_d;
            aw_idx_q   <= aw_idx_d;
            awlen_ok_q <= awlen_ok_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wlast_q    <= wlast_d;
            bid_q      <= bid_d;
            bresp_q    <= bresp_d;
`ifdef AXI_SLV_DELAY_EN
            rcnt_q     <= rcnt_d;
            bcnt_q     <= bcnt_d;
`endif
        end
    end

    // Memory survives reset; a same-edge read above already sampled old data.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (wstrb_q[k]) mem_q[aw_idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: expected R/B beats are queued
// when a request is driven and popped when the slave responds.
module tb_axi_sram_slave;

    localparam int ADDR_W = 12;
`ifdef AXI_SLV_DELAY_EN
    localparam int DLY = 3;
`else
    localparam int DLY = 0;
`endif

    logic        aclk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'd2;
    logic [1:0]  arburst = 2'd1;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = 3'd2;
    logic [1:0]  awburst = 2'd1;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [3:0]  wid = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b1;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    axi_sram_slave #(.ADDR_W(ADDR_W), .RESP_DELAY(3)) dut (
        .aclk(aclk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    r_exp_t      rq[$];
    b_exp_t      bq[$];
    logic [31:0] mdl[int];
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[ADDR_W+1:2]);
    endfunction

    task automatic push_r(input logic [31:0] a, input logic [3:0] id,
                          input logic [7:0] len);
        r_exp_t e;
        arid   = id;
        araddr = a;
        arlen  = len;
        e.id   = id;
        e.data = (len != 0) ? 32'd0 : mdl[widx(a)];
        e.resp = (len != 0) ? 2'b10 : 2'b00;
        rq.push_back(e);
    endtask

    task automatic push_w(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [3:0] id,
                          input logic [7:0] len, input logic last);
        b_exp_t e;
        logic [31:0] w;
        awid   = id;
        awaddr = a;
        awlen  = len;
        wdata  = d;
        wstrb  = s;
        wlast  = last;
        e.id   = id;
        e.resp = (len == 0 && last) ? 2'b00 : 2'b10;
        bq.push_back(e);
        if (len == 0 && last) begin
            w = mdl.exists(widx(a)) ? mdl[widx(a)] : 32'd0;
            for (int k = 0; k < 4; k++)
                if (s[k]) w[8*k +: 8] = d[8*k +: 8];
            mdl[widx(a)] = w;
        end
    endtask

    // Entered at the negedge after the AR handshake edge.
    task automatic r_collect(input int exp_lat);
        r_exp_t e;
        int lat = 1;
        while (!rvalid && lat < 40) begin
            @(negedge aclk);
            lat++;
        end
        if (exp_lat >= 0) chk("r_latency", lat, exp_lat);
        chk("arready_busy", arready, 1'b0);
        e = rq.pop_front();
        chk("rid", rid, e.id);
        chk("rdata", rdata, e.data);
        chk("rresp", rresp, e.resp);
        chk("rlast", rlast, 1'b1);
        rready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        rready = 1'b0;
        chk("rvalid_drop", rvalid, 1'b0);
        chk("arready_back", arready, 1'b1);
    endtask

    task automatic b_collect(input int exp_lat, input int hold);
        b_exp_t e;
        int lat = 1;
        while (!bvalid && lat < 40) begin
            @(negedge aclk);
            lat++;
        end
        if (exp_lat >= 0) chk("b_latency", lat, exp_lat);
        e = bq.pop_front();
        chk("bid", bid, e.id);
        chk("bresp", bresp, e.resp);
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            chk("b_hold_valid", bvalid, 1'b1);
            chk("b_hold_id", bid, e.id);
            chk("b_hold_aw", awready, 1'b0);
        end
        bready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bready = 1'b0;
        chk("bvalid_drop", bvalid, 1'b0);
        chk("awready_back", awready, 1'b1);
        chk("wready_back", wready, 1'b1);
    endtask

    task automatic drive_w(input int w_lead);
        bit awd = 0, wd = 0, awh, wh;
        int lead = 0, t = 0;
        wvalid  = 1'b1;
        awvalid = (w_lead == 0);
        while (!(awd && wd) && t < 40) begin
            awh = awvalid && awready;
            wh  = wvalid && wready;
            @(posedge aclk);
            @(negedge aclk);
            t++;
            if (awh) begin awd = 1; awvalid = 1'b0; end
            if (wh) begin wd = 1; wvalid = 1'b0; end
            if (wd && !awd && !awvalid) begin
                chk("wready_low", wready, 1'b0);
                lead++;
                if (lead >= w_lead) awvalid = 1'b1;
            end
        end
        chk("aw_w_done", {awd, wd}, 2'b11);
    endtask

    task automatic drive_r();
        int t = 0;
        arvalid = 1'b1;
        while (!arready && t < 40) begin
            @(negedge aclk);
            t++;
        end
        @(posedge aclk);
        @(negedge aclk);
        arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [3:0] id,
                            input logic [7:0] len, input logic last,
                            input int w_lead, input int hold);
        push_w(a, d, s, id, len, last);
        drive_w(w_lead);
        b_collect(2 + DLY, hold);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] id,
                           input logic [7:0] len);
        push_r(a, id, len);
        drive_r();
        r_collect(1 + DLY);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int seen;

        #12;
        chk("rst_arready", arready, 1'b1);
        chk("rst_awready", awready, 1'b1);
        chk("rst_wready", wready, 1'b1);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rid", rid, 4'd0);
        chk("rst_bid", bid, 4'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rresp", rresp, 2'd0);
        chk("rst_bresp", bresp, 2'd0);
        @(negedge aclk);
        reset = 1'b0;
        @(negedge aclk);

        do_write(32'h10, 32'hDEADBEEF, 4'hF, 4'd1, 8'd0, 1'b1, 0, 0);
        do_read(32'h10, 4'd0, 8'd0);

        do_write(32'h10, 32'h11223344, 4'b0101, 4'd2, 8'd0, 1'b1, 0, 0);
        chk("partial_model", mdl[widx(32'h10)], 32'hDE22BE44);
        do_read(32'h10, 4'd3, 8'd0);

        do_write(32'h30, 32'h0BADF00D, 4'hF, 4'd5, 8'd0, 1'b1, 3, 4);
        do_read(32'h30, 4'd6, 8'd0);

        do_read(32'h10, 4'd7, 8'd1);
        do_write(32'h10, 32'hFFFFFFFF, 4'hF, 4'd8, 8'd3, 1'b1, 0, 0);
        do_read(32'h10, 4'd9, 8'd0);
        do_write(32'h10, 32'h00000000, 4'hF, 4'd10, 8'd0, 1'b0, 0, 0);
        do_write(32'h10, 32'h00000000, 4'h0, 4'd11, 8'd0, 1'b1, 0, 0);
        do_read(32'h10, 4'd12, 8'd0);

        do_write(32'h20, 32'hA5A5A5A5, 4'hF, 4'd1, 8'd0, 1'b1, 0, 0);
        // AR handshake lands on the same edge as the write commit.
        push_r(32'h20, 4'd2, 8'd0);
        push_w(32'h20, 32'h5A5A5A5A, 4'hF, 4'd3, 8'd0, 1'b1);
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        arvalid = 1'b0;
        r_collect(1 + DLY);
        chk("same_edge_old", rq.size(), 0);
        b_collect(-1, 0);
        do_read(32'h20, 4'd4, 8'd0);
        do_read(32'h20 + (32'd4 << ADDR_W), 4'd5, 8'd0);

        for (int i = 0; i < 6; i++) begin
            a = {$urandom_range(0, 255), 2'b00};
            d = $urandom;
            do_write(a, d, 4'hF, 4'(i), 8'd0, 1'b1, i % 3, i % 2);
            do_read(a, 4'(i + 8), 8'd0);
        end

        push_r(32'h30, 4'd9, 8'd0);
        drive_r();
        seen = 0;
        while (!rvalid && seen < 40) begin
            @(negedge aclk);
            seen++;
        end
        chk("pre_rst_rvalid", rvalid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_rvalid", rvalid, 1'b0);
        chk("rst_mid_arready", arready, 1'b1);
        void'(rq.pop_back());
        @(negedge aclk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            if (rvalid || bvalid) seen++;
        end
        chk("no_resp_after_rst", seen, 0);
        do_read(32'h30, 4'd1, 8'd0);

        chk("rq_empty", rq.size(), 0);
        chk("bq_empty", bq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
